// File: rtl/trace_buffer_arbiter.sv
// Trace buffer arbiter: sole owner of the column trace buffer port.
// Display reads stream at one per clock and always win over tracer writes.
module trace_buffer_arbiter #(
    parameter int unsigned COLUMNS = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_column,
    input  logic [14:0] wr_data,
    input  logic        rd_req,
    output logic        rd_ready,
    input  logic [9:0]  rd_column,
    output logic        rd_valid,
    output logic [14:0] rd_data,
    output logic [9:0]  wr_count,
    output logic        wr_done,
    output logic        buf_cs,
    output logic        buf_we,
    output logic        buf_oe,
    output logic [9:0]  buf_column,
    output logic [14:0] buf_wdata,
    output logic        buf_drive,
    input  logic [14:0] buf_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StTail, StWr} state_e;

    localparam logic [10:0] ColLimit = 11'(COLUMNS);
    localparam logic [9:0]  CountMax = 10'(COLUMNS);

    state_e state_q, state_d;

    logic        buf_cs_q, buf_cs_d;
    logic        buf_we_q, buf_we_d;
    logic        buf_oe_q, buf_oe_d;
    logic        buf_drive_q, buf_drive_d;
    logic [9:0]  buf_column_q, buf_column_d;
    logic [14:0] buf_wdata_q, buf_wdata_d;

    // Read slots: slot1 = address on the bus, slot2 = buffer driving data.
    logic        slot1_vld_q, slot1_inr_q;
    logic        slot2_vld_q, slot2_inr_q;
    logic        rd_valid_q;
    logic [14:0] rd_data_q;

    logic [9:0]  wr_count_q, wr_count_d, wr_count_base;
    logic        wr_done_q, wr_done_d;
    logic        wr_inc;

    logic rd_accept, wr_accept;
    logic rd_in_range, wr_in_range;

    assign rd_in_range = {1'b0, rd_column} < ColLimit;
    assign wr_in_range = {1'b0, wr_column} < ColLimit;

    assign rd_ready  = (state_q != StWr);
    assign wr_ready  = (state_q == StIdle) && !rd_req;
    assign rd_accept = rd_req && rd_ready;
    assign wr_accept = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_cs_d     = buf_cs_q;
        buf_we_d     = buf_we_q;
        buf_oe_d     = buf_oe_q;
        buf_drive_d  = buf_drive_q;
        buf_column_d = buf_column_q;
        buf_wdata_d  = buf_wdata_q;

        unique case (state_q)
            StIdle:  state_d = rd_accept ? StRead : (wr_accept ? StWr : StIdle);
            StRead:  state_d = rd_accept ? StRead : StTail;
            StTail:  state_d = rd_accept ? StRead : StIdle;
            default: state_d = StIdle;
        endcase

        // Strobes are set up for the state being entered, so they register with it.
        unique case (state_d)
            StRead: begin
                buf_cs_d     = rd_in_range;
                buf_we_d     = 1'b0;
                buf_oe_d     = 1'b1;
                buf_drive_d  = 1'b0;
                buf_column_d = rd_column;
            end
            StTail: begin
                // Hold cs/oe/column so the buffer keeps driving the last read.
            end
            StWr: begin
                buf_cs_d     = wr_in_range;
                buf_we_d     = wr_in_range;
                buf_oe_d     = 1'b0;
                buf_drive_d  = 1'b1;
                buf_column_d = wr_column;
                buf_wdata_d  = wr_data;
            end
            default: begin
                buf_cs_d    = 1'b0;
                buf_we_d    = 1'b0;
                buf_oe_d    = 1'b0;
                buf_drive_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_cs_q     <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_oe_q     <= 1'b0;
            buf_drive_q  <= 1'b0;
            buf_column_q <= '0;
            buf_wdata_q  <= '0;
        end else begin
            buf_cs_q     <= buf_cs_d;
            buf_we_q     <= buf_we_d;
            buf_oe_q     <= buf_oe_d;
            buf_drive_q  <= buf_drive_d;
            buf_column_q <= buf_column_d;
            buf_wdata_q  <= buf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot1_vld_q <= 1'b0;
            slot1_inr_q <= 1'b0;
            slot2_vld_q <= 1'b0;
            slot2_inr_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            slot1_vld_q <= rd_accept;
            slot1_inr_q <= rd_in_range;
            slot2_vld_q <= slot1_vld_q;
            slot2_inr_q <= slot1_inr_q;
            rd_valid_q  <= slot2_vld_q;
            if (slot2_vld_q) begin
                rd_data_q <= slot2_inr_q ? buf_rdata : '0;
            end
        end
    end

    // frame_start clears first, so a write in the same cycle lands on a fresh count.
    always_comb begin
        wr_count_base = frame_start ? '0 : wr_count_q;
        wr_inc        = wr_accept && wr_in_range && (wr_count_base != CountMax);
        wr_count_d    = wr_count_base + 10'(wr_inc);
        wr_done_d     = wr_inc && (wr_count_d == CountMax);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            wr_count_q <= wr_count_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign buf_cs     = buf_cs_q;
    assign buf_we     = buf_we_q;
    assign buf_oe     = buf_oe_q;
    assign buf_drive  = buf_drive_q;
    assign buf_column = buf_column_q;
    assign buf_wdata  = buf_wdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign wr_count   = wr_count_q;
    assign wr_done    = wr_done_q;

    a_no_bus_fight: assert property (@(posedge clk) disable iff (reset)
        !(buf_drive_q && buf_oe_q));

    a_turnaround: assert property (@(posedge clk) disable iff (reset)
        (state_q == StRead || state_q == StTail) |=> !buf_drive_q);

endmodule

// File: tb/tb_trace_buffer_arbiter.sv
// Bench for trace_buffer_arbiter: buffer model, accept-history reference model,
// vector table, directed corner sequences and a randomized run.
module tb_trace_buffer_arbiter;

    localparam int Columns = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [9:0]  wr_column = '0;
    logic [14:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic        rd_ready;
    logic [9:0]  rd_column = '0;
    logic        rd_valid;
    logic [14:0] rd_data;
    logic [9:0]  wr_count;
    logic        wr_done;
    logic        buf_cs, buf_we, buf_oe, buf_drive;
    logic [9:0]  buf_column;
    logic [14:0] buf_wdata;
    logic [14:0] buf_rdata = '0;

    trace_buffer_arbiter #(.COLUMNS(Columns)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_column   (wr_column),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_ready    (rd_ready),
        .rd_column   (rd_column),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_count    (wr_count),
        .wr_done     (wr_done),
        .buf_cs      (buf_cs),
        .buf_we      (buf_we),
        .buf_oe      (buf_oe),
        .buf_column  (buf_column),
        .buf_wdata   (buf_wdata),
        .buf_drive   (buf_drive),
        .buf_rdata   (buf_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Buffer device: 1-cycle registered read port, write at the edge with cs && we.
    logic [14:0] mem [1024] = '{default: 15'h0};
    always @(posedge clk) begin
        if (buf_cs && buf_we) mem[buf_column] <= buf_wdata;
        if (buf_cs && buf_oe && !buf_we) buf_rdata <= mem[buf_column];
    end

    // Reference model: state is implied by which requests were accepted in the last two cycles.
    typedef struct { int unsigned due; logic [14:0] data; } pend_t;
    pend_t       pend_q[$];
    logic [14:0] golden [1024] = '{default: 15'h0};
    logic        model_ok = 1'b0;
    logic        h1_rd = 1'b0, h1_wr = 1'b0, h2_rd = 1'b0;
    logic        h1_rd_inr = 1'b0, h1_wr_inr = 1'b0;
    logic [9:0]  h1_col = '0;
    logic [14:0] h1_wdata = '0;
    int          m_count = 0;
    logic        m_done = 1'b0;

    logic m_rd_ready, m_wr_ready, m_rd_acc, m_wr_acc, m_rd_inr, m_wr_inr, m_inc;
    int   m_base;
    assign m_rd_ready = !h1_wr;
    assign m_wr_ready = !(h1_rd || h1_wr || h2_rd) && !rd_req;
    assign m_rd_acc   = rd_req && m_rd_ready;
    assign m_wr_acc   = wr_valid && m_wr_ready;
    assign m_rd_inr   = int'(rd_column) < Columns;
    assign m_wr_inr   = int'(wr_column) < Columns;
    assign m_base     = frame_start ? 0 : m_count;
    assign m_inc      = m_wr_acc && m_wr_inr && (m_base < Columns);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            model_ok <= 1'b1;
            h1_rd <= 1'b0; h1_wr <= 1'b0; h2_rd <= 1'b0;
            m_count <= 0;
            m_done <= 1'b0;
            pend_q.delete();
        end else begin
            h1_rd     <= m_rd_acc;
            h1_wr     <= m_wr_acc;
            h2_rd     <= h1_rd;
            h1_rd_inr <= m_rd_inr;
            h1_wr_inr <= m_wr_inr;
            h1_col    <= m_rd_acc ? rd_column : wr_column;
            h1_wdata  <= wr_data;
            if (m_rd_acc) pend_q.push_back('{cyc + 3, m_rd_inr ? golden[rd_column] : 15'h0});
            if (m_wr_acc && m_wr_inr) golden[wr_column] <= wr_data;
            m_count <= m_base + (m_inc ? 1 : 0);
            m_done  <= m_inc && (m_base + 1 == Columns);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("rd_ready", 32'(rd_ready), 32'(m_rd_ready));
            check("wr_ready", 32'(wr_ready), 32'(m_wr_ready));
            check("buf_drive", 32'(buf_drive), 32'(h1_wr));
            check("buf_we", 32'(buf_we), 32'(h1_wr && h1_wr_inr));
            check("buf_oe", 32'(buf_oe), 32'(h1_rd || h2_rd));
            check("no_bus_fight", 32'(buf_drive && buf_oe), 32'(0));
            if (h1_wr) begin
                check("buf_cs_wr", 32'(buf_cs), 32'(h1_wr_inr));
                check("buf_column_wr", 32'(buf_column), 32'(h1_col));
                check("buf_wdata", 32'(buf_wdata), 32'(h1_wdata));
            end else if (h1_rd) begin
                check("buf_cs_rd", 32'(buf_cs), 32'(h1_rd_inr));
                check("buf_column_rd", 32'(buf_column), 32'(h1_col));
            end else if (!h2_rd) begin
                check("buf_cs_idle", 32'(buf_cs), 32'(0));
            end
            while (pend_q.size() > 0 && pend_q[0].due < cyc) begin
                check("rd_missed", 32'(0), 32'(1));
                void'(pend_q.pop_front());
            end
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                check("rd_valid", 32'(rd_valid), 32'(1));
                check("rd_data", 32'(rd_data), 32'(pend_q[0].data));
                void'(pend_q.pop_front());
            end else begin
                check("rd_valid_idle", 32'(rd_valid), 32'(0));
            end
            check("wr_count", 32'(wr_count), 32'(m_count));
            check("wr_done", 32'(wr_done), 32'(m_done));
        end
    end

    // Tasks start and return at posedge + 1.
    task automatic do_write(input logic [9:0] col, input logic [14:0] d);
        bit ok = 0;
        int n = 0;
        wr_valid = 1'b1; wr_column = col; wr_data = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = m_wr_ready;
            @(posedge clk); #1;
            n++;
        end
        wr_valid = 1'b0;
        if (!ok) check("write_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_read(input logic [9:0] col);
        bit ok = 0;
        int n = 0;
        rd_req = 1'b1; rd_column = col;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = m_rd_ready;
            @(posedge clk); #1;
            n++;
        end
        rd_req = 1'b0;
        if (!ok) check("read_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        bit          is_wr;
        logic [9:0]  col;
        logic [14:0] data;
        logic [14:0] exp_rd;
        logic [9:0]  exp_count;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int done_cnt, vcount, first_valid, oe_cnt, drive_cnt, n;

        vecs[0] = '{1'b1, 10'd5,   15'h1ABC, 15'h0,    10'd1};
        vecs[1] = '{1'b0, 10'd5,   15'h0,    15'h1ABC, 10'd1};
        vecs[2] = '{1'b1, 10'd700, 15'h7FFF, 15'h0,    10'd1};
        vecs[3] = '{1'b0, 10'd700, 15'h0,    15'h0,    10'd1};
        vecs[4] = '{1'b1, 10'd639, 15'h2345, 15'h0,    10'd2};
        vecs[5] = '{1'b0, 10'd639, 15'h0,    15'h2345, 10'd2};
        vecs[6] = '{1'b0, 10'd640, 15'h0,    15'h0,    10'd2};
        vecs[7] = '{1'b1, 10'd5,   15'h0F0F, 15'h0,    10'd3};
        vecs[8] = '{1'b0, 10'd5,   15'h0,    15'h0F0F, 10'd3};

        // Reset and idle state.
        reset = 1'b1; wr_valid = 1'b1; wr_column = 10'd700;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_buf_cs", 32'(buf_cs), 32'(0));
        check("reset_buf_oe", 32'(buf_oe), 32'(0));
        check("reset_buf_drive", 32'(buf_drive), 32'(0));
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_wr_count", 32'(wr_count), 32'(0));
        check("reset_wr_ready", 32'(wr_ready), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0; wr_valid = 1'b0;
        idle(2);

        // Vector table.
        frame_start = 1'b1; idle(1); frame_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].col, vecs[i].data);
                @(negedge clk);
                check("vec_wr_column", 32'(buf_column), 32'(vecs[i].col));
                check("vec_wr_cs", 32'(buf_cs), 32'(int'(vecs[i].col) < Columns));
                check("vec_wr_drive", 32'(buf_drive), 32'(1));
                check("vec_wr_count", 32'(wr_count), 32'(vecs[i].exp_count));
                @(posedge clk); #1;
            end else begin
                do_read(vecs[i].col);
                repeat (3) @(negedge clk);
                check("vec_rd_valid", 32'(rd_valid), 32'(1));
                check("vec_rd_data", 32'(rd_data), 32'(vecs[i].exp_rd));
                check("vec_rd_count", 32'(wr_count), 32'(vecs[i].exp_count));
                @(posedge clk); #1;
            end
        end
        idle(3);

        // Full frame of writes; wr_done once, then saturation.
        frame_start = 1'b1; idle(1); frame_start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < Columns; c++) begin
            do_write(10'(c), 15'(c * 7 + 3));
            @(negedge clk);
            if (wr_done) done_cnt++;
            @(posedge clk); #1;
        end
        check("frame_count", 32'(wr_count), 32'(Columns));
        check("frame_done_pulses", 32'(done_cnt), 32'(1));
        do_write(10'd0, 15'd3);
        @(negedge clk);
        check("saturated_count", 32'(wr_count), 32'(Columns));
        check("saturated_no_done", 32'(wr_done), 32'(0));
        @(posedge clk); #1;
        idle(3);

        // Full-line read stream.
        vcount = 0; first_valid = -1; oe_cnt = 0; drive_cnt = 0;
        for (int i = 0; i < 646; i++) begin
            rd_req = (i < Columns);
            rd_column = 10'(i);
            @(negedge clk);
            if (rd_valid) begin
                if (first_valid < 0) first_valid = i;
                check("stream_data", 32'(rd_data), 32'(vcount * 7 + 3));
                vcount++;
            end
            if (buf_oe) oe_cnt++;
            if (buf_drive) drive_cnt++;
            @(posedge clk); #1;
        end
        check("stream_valid_count", 32'(vcount), 32'(Columns));
        check("stream_first_valid", 32'(first_valid), 32'(3));
        check("stream_oe_cycles", 32'(oe_cnt), 32'(Columns + 1));
        check("stream_drive_cycles", 32'(drive_cnt), 32'(0));
        idle(3);

        // Read and write contend: reads win, write waits out READ, TAIL and IDLE.
        rd_req = 1'b1; rd_column = 10'd10;
        wr_valid = 1'b1; wr_column = 10'd20; wr_data = 15'h1234;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("contend_wr_ready", 32'(wr_ready), 32'(0));
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!buf_drive && n < 10);
        check("contend_write_delay", 32'(n), 32'(4));
        @(posedge clk); #1;
        wr_valid = 1'b0;
        idle(3);

        // Reset in the middle of a 3-deep read stream.
        rd_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rd_column = 10'(k);
            @(posedge clk); #1;
        end
        rd_req = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_buf_cs", 32'(buf_cs), 32'(0));
        check("midreset_buf_oe", 32'(buf_oe), 32'(0));
        for (int k = 0; k < 5; k++) begin
            check("midreset_no_rd_valid", 32'(rd_valid), 32'(0));
            @(negedge clk);
        end
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(0, 499) == 0);
            frame_start = ($urandom_range(0, 99) == 0);
            rd_req      = ($urandom_range(0, 99) < 35);
            rd_column   = 10'($urandom_range(0, 719));
            wr_valid    = ($urandom_range(0, 99) < 60);
            wr_column   = 10'($urandom_range(0, 719));
            wr_data     = 15'($urandom);
            @(posedge clk); #1;
        end
        reset = 1'b0; frame_start = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
        idle(6);
        @(negedge clk);
        check("pending_drained", 32'(pend_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trace_buffer_arbiter.md
Name: trace_buffer_arbiter

Overview:
Sole owner of the per-column trace buffer port (cs/we/oe/column plus bidirectional height/side/tex).
Arbitrates between two requesters:
- the tracer, which writes one column trace at a time;
- the display pipeline, which streams column reads at one per clock during visible lines.
The arbiter generates all buffer strobes, handles bus turnaround, and tracks how many columns the tracer has written in the current frame.

Parameters:
COLUMNS, 640, number of valid columns; column indices >= COLUMNS are out of range.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse; clears write tracking
wr_valid  in  1  tracer write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_column  in  10  write column
wr_data  in  15  {height[7:0], side, tex[5:0]}
rd_req  in  1  display read request
rd_ready  out  1  read accepted when rd_req && rd_ready
rd_column  in  10  read column
rd_valid  out  1  rd_data valid this cycle
rd_data  out  15  {height, side, tex}
wr_count  out  10  in-range writes accepted since frame_start, saturating at COLUMNS
wr_done  out  1  one-cycle pulse when wr_count reaches COLUMNS
buf_cs, buf_we, buf_oe  out  1 each  buffer strobes
buf_column  out  10  buffer address
buf_wdata  out  15  write data toward the buffer bus
buf_drive  out  1  tri-state enable for buf_wdata onto the buffer bus (done at top level)
buf_rdata  in  15  buffer bus as seen by the arbiter

Behaviour:
- Outputs: all buf_* outputs, rd_valid, rd_data, wr_count and wr_done are registered. Only wr_ready and rd_ready are combinational from state and rd_req.
- Reset: state IDLE. All registered outputs go to 0: buf_cs, buf_we, buf_oe, buf_drive, buf_column, buf_wdata, rd_valid, rd_data, wr_count, wr_done.
- Reset mid-operation: any in-flight reads are discarded and produce no rd_valid. The buffer bus is released on the next edge.
- Buffer model: a read port with 1-cycle registered latency while cs && oe && !we. A write is committed at the edge where cs && we.
- States: IDLE, READ, TAIL, WR.
- rd_ready = 1 in IDLE, READ and TAIL; 0 in WR.
- wr_ready = (state == IDLE) && !rd_req. Reads always have priority.
- IDLE:
  - rd_req accepted -> READ.
  - else wr_valid accepted -> WR.
  - Bus undriven (cs = oe = drive = 0).
- READ:
  - Outputs cs = 1, oe = 1, we = 0, buf_column = column of the read accepted in the previous cycle.
  - New rd_req accepted -> stay in READ (one read per clock).
  - No request -> TAIL.
- TAIL:
  - cs = oe = 1, column held, so the buffer keeps driving the final read's data.
  - rd_req accepted -> READ; else -> IDLE.
  - The IDLE cycle that follows is the mandatory turnaround gap before any write drives the bus.
- Read latency: a request accepted in cycle T has its address on buf_column in T+1. buf_rdata is captured at the end of T+2. rd_valid is high in T+3 with that data. Back-to-back requests give one rd_valid per cycle, in order.
- Out-of-range read (rd_column >= COLUMNS):
  - accepted with identical timing;
  - buffer cs deasserted in its slot, but oe/cs are held for any neighbouring in-range slots;
  - rd_data = 0 with rd_valid = 1.
- WR state (one cycle):
  - cs = 1, we = 1, oe = 0, drive = 1;
  - buf_column and buf_wdata come from the accepted request.
  - Then -> IDLE.
  - Out-of-range write: accepted, cs = we = 0, data not written, not counted.
  - Write throughput: 1 per 2 cycles without read contention.
- Bus conflict invariant: buf_drive && buf_oe is never 1. buf_drive is never 1 in the cycle after READ or TAIL.
- wr_count:
  - increments on each accepted in-range write;
  - saturates at COLUMNS;
  - wr_done pulses in the cycle wr_count becomes COLUMNS.
  - Rewriting a column still counts (no per-column tracking).
- frame_start: clears wr_count. If a write is accepted in the same cycle, wr_count becomes 1.

Test Plan:
- Reset, then idle: all buf_* = 0, rd_valid = 0, wr_count = 0. wr_ready = 1 while wr_valid = 1.
- Write col 5 data 0x1ABC; later read col 5 -> WR cycle has buf_column = 5, cs = we = drive = 1. rd_valid 3 cycles after accept with rd_data = 0x1ABC.
- Stream reads cols 0..639 with rd_req held: rd_valid high for 640 consecutive cycles starting at accept+3, data in column order, buf_oe continuous, buf_drive = 0 throughout.
- Hold wr_valid and rd_req together for 4 cycles: wr_ready = 0 throughout. After rd_req drops, the write issues only after TAIL and IDLE (≥ 2 cycles after the last READ).
- 640 in-range writes after frame_start: wr_done pulses once on the 640th. A 641st write leaves wr_count = 640. Write col 700 -> accepted, no buffer cs, count unchanged.
- Assert reset during a 3-deep read stream: no rd_valid afterwards, buf_cs = buf_oe = 0 on the next cycle.
